// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM read-port arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE   = 2'd0,
    OWNER_IFETCH = 2'd1,
    OWNER_DMEM   = 2'd2
  } owner_e;

  localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/sram_read_arbiter_if.sv
// Synchronous SRAM read port: enable/address issued in cycle N, data valid in N+1.
interface MemoryInterface #(
    parameter int WIDTH = 32
);
    logic             enable;
    logic [WIDTH-1:0] address;
    logic [WIDTH-1:0] data;

    modport read_out (output enable, output address, input data);
    modport read_in  (input enable, input address, output data);
endinterface

// File: rtl/sram_arb_grant.sv
// Two-requester one-hot grant generator. Round-robin when SRAM_ARB_RR_EN is
// defined, otherwise fixed dmem-over-ifetch priority.
module sram_arb_grant
    import sram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_ifetch,
    input  logic req_dmem,
    output logic gnt_ifetch,
    output logic gnt_dmem
);

`ifdef SRAM_ARB_RR_EN
    owner_e last_grant;

    // Reset to IFETCH so dmem wins the first contention, matching fixed mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWNER_IFETCH;
        end else if (gnt_ifetch) begin
            last_grant <= OWNER_IFETCH;
        end else if (gnt_dmem) begin
            last_grant <= OWNER_DMEM;
        end
    end

    always_comb begin
        gnt_ifetch = 1'b0;
        gnt_dmem   = 1'b0;
        if (!rst) begin
            if (req_ifetch && req_dmem) begin
                if (last_grant == OWNER_DMEM) begin
                    gnt_ifetch = 1'b1;
                end else begin
                    gnt_dmem = 1'b1;
                end
            end else begin
                gnt_ifetch = req_ifetch;
                gnt_dmem   = req_dmem;
            end
        end
    end
`else
    logic unused_clk;
    assign unused_clk = clk;

    always_comb begin
        gnt_ifetch = 1'b0;
        gnt_dmem   = 1'b0;
        if (!rst) begin
            gnt_dmem   = req_dmem;
            gnt_ifetch = req_ifetch && !req_dmem;
        end
    end
`endif

endmodule

// File: rtl/sram_read_arbiter.sv
// Shares one synchronous SRAM read port between fetch and load paths.
// Optional feature macro: SRAM_ARB_RR_EN (round-robin instead of dmem priority).
module sram_read_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   ifetch_req_valid,
    input  logic [WIDTH-1:0]       ifetch_req_addr,
    output logic                   ifetch_req_ready,
    input  logic                   ifetch_flush,
    output logic                   ifetch_rsp_valid,
    output logic [WIDTH-1:0]       ifetch_rsp_data,

    input  logic                   dmem_req_valid,
    input  logic [WIDTH-1:0]       dmem_req_addr,
    output logic                   dmem_req_ready,
    output logic                   dmem_rsp_valid,
    output logic [WIDTH-1:0]       dmem_rsp_data,

    MemoryInterface.read_out       sramport,

    output logic [STALL_CNT_W-1:0] ifetch_stall_cycles
);

    // Handshake: a request transfers when valid && ready in the same cycle;
    // ready is the combinational grant and never waits on ready->valid.
    // Responses have no backpressure and appear exactly one cycle later.

    if (DEPTH < 2) begin : g_depth_check
        $error("sram_read_arbiter: DEPTH must be at least 2");
    end

    logic   gnt_ifetch;
    logic   gnt_dmem;
    owner_e owner;
    owner_e owner_next;

    sram_arb_grant u_grant (
        .clk        (clk),
        .rst        (rst),
        .req_ifetch (ifetch_req_valid),
        .req_dmem   (dmem_req_valid),
        .gnt_ifetch (gnt_ifetch),
        .gnt_dmem   (gnt_dmem)
    );

    assign ifetch_req_ready = gnt_ifetch;
    assign dmem_req_ready   = gnt_dmem;

    always_comb begin
        sramport.enable  = gnt_ifetch | gnt_dmem;
        sramport.address = '0;
        if (gnt_ifetch) begin
            sramport.address = ifetch_req_addr;
        end else if (gnt_dmem) begin
            sramport.address = dmem_req_addr;
        end
    end

    // A flushed fetch still reads the SRAM; only its response is dropped.
    always_comb begin
        owner_next = OWNER_NONE;
        if (gnt_ifetch && !ifetch_flush) begin
            owner_next = OWNER_IFETCH;
        end else if (gnt_dmem) begin
            owner_next = OWNER_DMEM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= OWNER_NONE;
        end else begin
            owner <= owner_next;
        end
    end

    // Gating with rst kills the response of a read granted just before reset.
    assign ifetch_rsp_valid = (owner == OWNER_IFETCH) && !rst;
    assign dmem_rsp_valid   = (owner == OWNER_DMEM) && !rst;
    assign ifetch_rsp_data  = sramport.data;
    assign dmem_rsp_data    = sramport.data;

    always_ff @(posedge clk) begin
        if (rst) begin
            ifetch_stall_cycles <= '0;
        end else if (ifetch_req_valid && !ifetch_req_ready &&
                     (ifetch_stall_cycles != {STALL_CNT_W{1'b1}})) begin
            ifetch_stall_cycles <= ifetch_stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Directed bench for sram_read_arbiter; expectations follow SRAM_ARB_RR_EN.
module tb_sram_read_arbiter;
  import sram_arb_pkg::*;

  localparam int W = 32;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         ifetch_req_valid, ifetch_req_ready, ifetch_flush, ifetch_rsp_valid;
  logic [W-1:0] ifetch_req_addr, ifetch_rsp_data;
  logic         dmem_req_valid, dmem_req_ready, dmem_rsp_valid;
  logic [W-1:0] dmem_req_addr, dmem_rsp_data;
  logic [31:0]  ifetch_stall_cycles;

  MemoryInterface #(.WIDTH(W)) sram_if ();

  sram_read_arbiter #(.WIDTH(W), .DEPTH(1024)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ifetch_req_valid    (ifetch_req_valid),
    .ifetch_req_addr     (ifetch_req_addr),
    .ifetch_req_ready    (ifetch_req_ready),
    .ifetch_flush        (ifetch_flush),
    .ifetch_rsp_valid    (ifetch_rsp_valid),
    .ifetch_rsp_data     (ifetch_rsp_data),
    .dmem_req_valid      (dmem_req_valid),
    .dmem_req_addr       (dmem_req_addr),
    .dmem_req_ready      (dmem_req_ready),
    .dmem_rsp_valid      (dmem_rsp_valid),
    .dmem_rsp_data       (dmem_rsp_data),
    .sramport            (sram_if),
    .ifetch_stall_cycles (ifetch_stall_cycles)
  );

  // SRAM model: word at address a holds a*3 + 0x1000_0000.
  function automatic logic [W-1:0] sram_word(input logic [W-1:0] a);
    return a * 3 + 32'h1000_0000;
  endfunction

  initial sram_if.data = '0;
  always @(posedge clk) begin
    if (sram_if.enable) sram_if.data <= sram_word(sram_if.address);
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] dexp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [W-1:0] ia,
                       input logic dv, input logic [W-1:0] da, input logic fl);
    ifetch_req_valid = iv;
    ifetch_req_addr  = ia;
    dmem_req_valid   = dv;
    dmem_req_addr    = da;
    ifetch_flush     = fl;
  endtask

  // One request cycle starting at a negedge: checks grant/SRAM drive, then the response.
  task automatic cycle(input string tag, input logic iv, input logic [W-1:0] ia,
                       input logic dv, input logic [W-1:0] da, input logic fl,
                       input logic exp_if, input logic exp_dm);
    logic if_pend, dm_pend;
    logic [W-1:0] exp_addr;
    drive(iv, ia, dv, da, fl);
    #1;
    chk({tag, ".if_rdy"}, ifetch_req_ready, exp_if);
    chk({tag, ".dm_rdy"}, dmem_req_ready, exp_dm);
    chk({tag, ".en"}, sram_if.enable, exp_if | exp_dm);
    exp_addr = exp_if ? ia : (exp_dm ? da : '0);
    chk({tag, ".addr"}, sram_if.address, exp_addr);
    if_pend = exp_if && !fl;
    dm_pend = exp_dm;
    if (if_pend) exp_q.push_back(sram_word(ia));
    if (dm_pend) dexp_q.push_back(sram_word(da));
    @(negedge clk);
    chk({tag, ".if_rsp_v"}, ifetch_rsp_valid, if_pend);
    chk({tag, ".dm_rsp_v"}, dmem_rsp_valid, dm_pend);
    if (if_pend && exp_q.size() > 0) chk({tag, ".if_data"}, ifetch_rsp_data, exp_q.pop_front());
    if (dm_pend && dexp_q.size() > 0) chk({tag, ".dm_data"}, dmem_rsp_data, dexp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst.if_rdy", ifetch_req_ready, 0);
    chk("rst.dm_rdy", dmem_req_ready, 0);
    chk("rst.en", sram_if.enable, 0);
    chk("rst.addr", sram_if.address, 0);
    chk("rst.if_rsp_v", ifetch_rsp_valid, 0);
    chk("rst.dm_rsp_v", dmem_rsp_valid, 0);
    chk("rst.stall", ifetch_stall_cycles, 0);
    @(negedge clk);
    rst = 1'b0;

    // Fetch alone, back to back
    cycle("fa0", 1, 32'h0, 0, 0, 0, 1, 0);
    cycle("fa1", 1, 32'h4, 0, 0, 0, 1, 0);
    cycle("fa2", 1, 32'h8, 0, 0, 0, 1, 0);
    chk("fa.data_hand", sram_word(32'h8), 32'h1000_0018);
    chk("fa.stall", ifetch_stall_cycles, 0);

    // Contention: dmem first, then alternate (RR) or dmem always (fixed)
    for (int i = 0; i < 4; i++) begin
      logic dm_wins;
      dm_wins = RR ? (i % 2 == 0) : 1'b1;
      cycle($sformatf("ct%0d", i), 1, 32'h20 + i * 4, 1, 32'h30 + i * 4, 0, !dm_wins, dm_wins);
    end
    chk("ct.stall", ifetch_stall_cycles, RR ? 32'd2 : 32'd4);

    // Flush drops the granted fetch response; next fetch and dmem are unaffected
    cycle("fl0", 1, 32'h10, 0, 0, 1, 1, 0);
    cycle("fl1", 1, 32'h40, 0, 0, 0, 1, 0);
    cycle("fl2", 0, 0, 1, 32'h50, 1, 0, 1);

    // Reset mid-read: dmem granted in N, rst in N+1
    drive(0, 0, 1, 32'h60, 0);
    #1;
    chk("rm.dm_rdy", dmem_req_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 32'h64, 1, 32'h68, 0);
    #1;
    chk("rm.dm_rsp_v", dmem_rsp_valid, 0);
    chk("rm.if_rsp_v", ifetch_rsp_valid, 0);
    chk("rm.dm_rdy_rst", dmem_req_ready, 0);
    chk("rm.if_rdy_rst", ifetch_req_ready, 0);
    chk("rm.en", sram_if.enable, 0);
    chk("rm.addr", sram_if.address, 0);
    @(negedge clk);
    chk("rm.stall", ifetch_stall_cycles, 0);
    chk("rm.dm_rsp_v2", dmem_rsp_valid, 0);
    rst = 1'b0;
    cycle("post_rst", 1, 32'h70, 0, 0, 0, 1, 0);

    // Saturation: preload near max, keep fetch stalled
    force dut.ifetch_stall_cycles = 32'hFFFF_FFFD;
    #1;
    release dut.ifetch_stall_cycles;
    for (int i = 0; i < 8; i++) begin
      logic dm_wins;
      dm_wins = RR ? (i % 2 == 0) : 1'b1;
      cycle($sformatf("sat%0d", i), 1, 32'h80, 1, 32'h90, 0, !dm_wins, dm_wins);
      if (i == 0) chk("sat.step", ifetch_stall_cycles, 32'hFFFF_FFFE);
    end
    chk("sat.hold", ifetch_stall_cycles, 32'hFFFF_FFFF);

    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sb.empty", exp_q.size() + dexp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
